needs_engine: RTL and testbench

Upstream stage of the status generator. Holds the six 4-bit need levels (hunger, happiness, health, hygiene, energy, social; 0 = fully satisfied, 15 = worst). Levels grow over time from a prescaled game tick and fall when the player issues care actions. The six level outputs drive the status generator's need inputs directly. A small AWAKE/ASLEEP/DEAD state machine gates both ageing and actions.

---
 rtl/tama_pkg.sv | 30 +++
 rtl/need_counter.sv | 52 +++++
 rtl/needs_engine.sv | 157 +++++++++++++++
 tb/tb_needs_engine.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tama_pkg.sv
// rtl/tama_pkg.sv - shared constants for the needs engine: action codes, states, level limits, action deltas
package tama_pkg;

    localparam int NEED_W = 4;
    localparam logic [NEED_W-1:0] NEED_MAX   = 4'd15;
    localparam logic [NEED_W-1:0] NEED_ALERT = 4'd12;

    localparam logic [2:0] ACT_FEED      = 3'd0;
    localparam logic [2:0] ACT_PLAY      = 3'd1;
    localparam logic [2:0] ACT_MEDICINE  = 3'd2;
    localparam logic [2:0] ACT_CLEAN     = 3'd3;
    localparam logic [2:0] ACT_SLEEP     = 3'd4;
    localparam logic [2:0] ACT_WAKE      = 3'd5;
    localparam logic [2:0] ACT_SOCIALIZE = 3'd6;

    typedef enum logic [1:0] {
        ST_AWAKE  = 2'd0,
        ST_ASLEEP = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    localparam logic [NEED_W-1:0] FEED_DEC      = 4'd4;
    localparam logic [NEED_W-1:0] PLAY_DEC      = 4'd4;
    localparam logic [NEED_W-1:0] PLAY_ENERGY   = 4'd1;
    localparam logic [NEED_W-1:0] MED_DEC       = 4'd6;
    localparam logic [NEED_W-1:0] SOC_DEC       = 4'd4;
    localparam logic [NEED_W-1:0] SOC_HAPPY_DEC = 4'd1;
    localparam logic [NEED_W-1:0] SLEEP_DRAIN   = 4'd1;

endpackage

// File: rtl/need_counter.sv
// rtl/need_counter.sv - one need level: tick phase counter plus saturating 0..15 level register
module need_counter
    import tama_pkg::*;
#(
    parameter int PERIOD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic              age_en,
    input  logic              force_age,
    input  logic              clear,
    input  logic [NEED_W-1:0] inc,
    input  logic [NEED_W-1:0] dec,
    output logic [NEED_W-1:0] level
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [PW-1:0]              phase;
    logic                       wrap;
    logic                       age;
    logic signed [NEED_W+1:0]   sum;

    assign wrap = age_en && (phase == PW'(PERIOD - 1));
    assign age  = age_en && (wrap || force_age);

    // Ageing and action deltas fold into one signed sum so both land on the same edge.
    assign sum = $signed({2'b00, level})
               + $signed({{(NEED_W + 1){1'b0}}, age})
               + $signed({2'b00, inc})
               - $signed({2'b00, dec});

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            level <= '0;
        end else if (!freeze) begin
            if (age_en) begin
                phase <= wrap ? '0 : phase + 1'b1;
            end
            if (clear || sum[NEED_W+1]) begin
                level <= '0;
            end else if (sum[NEED_W]) begin
                level <= NEED_MAX;
            end else begin
                level <= sum[NEED_W-1:0];
            end
        end
    end

endmodule

// File: rtl/needs_engine.sv
// rtl/needs_engine.sv - six need levels aged by a prescaled game tick and lowered by care actions
module needs_engine
    import tama_pkg::*;
#(
    parameter int TICK_DIV    = 50000000,
    parameter int HUNGER_PER  = 2,
    parameter int HAPPY_PER   = 3,
    parameter int HYGIENE_PER = 4,
    parameter int ENERGY_PER  = 3,
    parameter int SOCIAL_PER  = 5,
    parameter int HEALTH_PER  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              action_valid,
    input  logic [2:0]        action_code,
    output logic              action_ready,
    output logic [NEED_W-1:0] hunger,
    output logic [NEED_W-1:0] happiness,
    output logic [NEED_W-1:0] health,
    output logic [NEED_W-1:0] hygiene,
    output logic [NEED_W-1:0] energy,
    output logic [NEED_W-1:0] social,
    output logic              asleep,
    output logic              dead,
    output logic              tick
);

    localparam int PSW = $clog2(TICK_DIV);

    state_t              state;
    logic [PSW-1:0]      pre_cnt;
    logic                accept;
    logic                act;
    logic                awake;
    logic                go_dead;
    logic                freeze;
    logic                health_alert;
    logic [NEED_W-1:0]   hunger_dec, happy_dec, health_dec, energy_inc, energy_dec, social_dec;
    logic                hygiene_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (pre_cnt == PSW'(TICK_DIV - 1)) begin
            pre_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

    assign accept       = action_valid && action_ready;
    assign awake        = (state == ST_AWAKE);
    assign act          = accept && awake;
    assign go_dead      = (hunger == NEED_MAX) || (health == NEED_MAX);
    // Freezing on the transition cycle too keeps the levels exactly as they were when death was seen.
    assign freeze       = (state == ST_DEAD) || go_dead;
    assign health_alert = (hunger >= NEED_ALERT) || (hygiene >= NEED_ALERT);

    always_comb begin
        hunger_dec  = '0;
        happy_dec   = '0;
        health_dec  = '0;
        energy_inc  = '0;
        energy_dec  = '0;
        social_dec  = '0;
        hygiene_clr = 1'b0;
        if (act) begin
            case (action_code)
                ACT_FEED:      hunger_dec = FEED_DEC;
                ACT_PLAY:      begin happy_dec = PLAY_DEC; energy_inc = PLAY_ENERGY; end
                ACT_MEDICINE:  health_dec = MED_DEC;
                ACT_CLEAN:     hygiene_clr = 1'b1;
                ACT_SOCIALIZE: begin social_dec = SOC_DEC; happy_dec = SOC_HAPPY_DEC; end
                default:       ;
            endcase
        end
        if (tick && state == ST_ASLEEP) begin
            energy_dec = SLEEP_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_AWAKE;
            asleep       <= 1'b0;
            dead         <= 1'b0;
            action_ready <= 1'b1;
        end else begin
            case (state)
                ST_AWAKE: begin
                    if (go_dead) begin
                        state        <= ST_DEAD;
                        dead         <= 1'b1;
                        action_ready <= 1'b0;
                    end else if (accept && action_code == ACT_SLEEP) begin
                        state  <= ST_ASLEEP;
                        asleep <= 1'b1;
                    end
                end
                ST_ASLEEP: begin
                    if (go_dead) begin
                        state        <= ST_DEAD;
                        asleep       <= 1'b0;
                        dead         <= 1'b1;
                        action_ready <= 1'b0;
                    end else if ((accept && action_code == ACT_WAKE) || energy == '0) begin
                        state  <= ST_AWAKE;
                        asleep <= 1'b0;
                    end
                end
                ST_DEAD: ;
                default: begin
                    state        <= ST_AWAKE;
                    asleep       <= 1'b0;
                    dead         <= 1'b0;
                    action_ready <= 1'b1;
                end
            endcase
        end
    end

    need_counter #(.PERIOD(HUNGER_PER)) u_hunger (
        .clk(clk), .reset(reset), .freeze(freeze), .age_en(tick), .force_age(1'b0),
        .clear(1'b0), .inc('0), .dec(hunger_dec), .level(hunger)
    );

    need_counter #(.PERIOD(HAPPY_PER)) u_happiness (
        .clk(clk), .reset(reset), .freeze(freeze), .age_en(tick && awake), .force_age(1'b0),
        .clear(1'b0), .inc('0), .dec(happy_dec), .level(happiness)
    );

    need_counter #(.PERIOD(HEALTH_PER)) u_health (
        .clk(clk), .reset(reset), .freeze(freeze), .age_en(tick), .force_age(health_alert),
        .clear(1'b0), .inc('0), .dec(health_dec), .level(health)
    );

    need_counter #(.PERIOD(HYGIENE_PER)) u_hygiene (
        .clk(clk), .reset(reset), .freeze(freeze), .age_en(tick), .force_age(1'b0),
        .clear(hygiene_clr), .inc('0), .dec('0), .level(hygiene)
    );

    // Energy only ages while awake; asleep it drains through energy_dec instead.
    need_counter #(.PERIOD(ENERGY_PER)) u_energy (
        .clk(clk), .reset(reset), .freeze(freeze), .age_en(tick && awake), .force_age(1'b0),
        .clear(1'b0), .inc(energy_inc), .dec(energy_dec), .level(energy)
    );

    need_counter #(.PERIOD(SOCIAL_PER)) u_social (
        .clk(clk), .reset(reset), .freeze(freeze), .age_en(tick), .force_age(1'b0),
        .clear(1'b0), .inc('0), .dec(social_dec), .level(social)
    );

endmodule

// File: tb/tb_needs_engine.sv
// tb/tb_needs_engine.sv - scoreboard bench for needs_engine with directed, hand-computed vectors
module tb_needs_engine;
    import tama_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       action_valid = 1'b0;
    logic [2:0] action_code = 3'd0;
    logic       action_ready, asleep, dead, tick;
    logic [3:0] hunger, happiness, health, hygiene, energy, social;

    always #5 clk = ~clk;

    needs_engine #(
        .TICK_DIV(4), .HUNGER_PER(2), .HAPPY_PER(3), .HYGIENE_PER(4),
        .ENERGY_PER(3), .SOCIAL_PER(5), .HEALTH_PER(6)
    ) dut (
        .clk(clk), .reset(reset), .action_valid(action_valid), .action_code(action_code),
        .action_ready(action_ready), .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .social(social), .asleep(asleep), .dead(dead),
        .tick(tick)
    );

    // Observed vector: levels (hunger..social), then asleep, dead, action_ready, tick.
    logic [27:0] obs;
    assign obs = {hunger, happiness, health, hygiene, energy, social, asleep, dead, action_ready, tick};

    localparam logic [27:0] M_ALL  = 28'hFFFFFFF;
    localparam logic [27:0] M_TICK = 28'h0000001;

    typedef struct {
        int          at;
        string       name;
        logic [27:0] exp;
        logic [27:0] mask;
    } chk_t;

    chk_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [27:0] v(int h, int hp, int he, int hy, int e, int s,
                                      int a, int d, int r, int t);
        return {4'(h), 4'(hp), 4'(he), 4'(hy), 4'(e), 4'(s), 1'(a), 1'(d), 1'(r), 1'(t)};
    endfunction

    task automatic expect_now(input string nm, input logic [27:0] e, input logic [27:0] m);
        chk_t c;
        c.at = cyc; c.name = nm; c.exp = e; c.mask = m;
        q.push_back(c);
    endtask

    // Monitor: retires every expectation stamped for the current cycle.
    initial begin
        chk_t c;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].at <= cyc) begin
                c = q.pop_front();
                n_cmp++;
                if (((obs ^ c.exp) & c.mask) != 28'h0) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h (mask %h) at cycle %0d",
                             c.name, obs & c.mask, c.exp & c.mask, c.mask, cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_tick();
        int b = 0;
        do begin
            step();
            b++;
        end while (!tick && b < 64);
        if (!tick) begin
            n_cmp++;
            n_fail++;
            $display("FAIL tick_timeout: no tick in %0d cycles, required one within 4", b);
        end
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            wait_tick();
            step();
        end
    endtask

    task automatic do_action(input logic [2:0] code);
        action_valid = 1'b1;
        action_code  = code;
        step();
        action_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        action_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_now("reset_state", v(0,0,0,0,0,0, 0,0,1,0), M_ALL);
    endtask

    initial begin
        // Idle ageing and tick timing
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            step();
            expect_now($sformatf("tick_cycle%0d", c), v(0,0,0,0,0,0, 0,0,0,(c == 4) ? 1 : 0), M_TICK);
        end
        step();
        run_ticks(1);
        expect_now("idle_t2", v(1,0,0,0,0,0, 0,0,1,0), M_ALL);
        run_ticks(2);
        expect_now("idle_t4", v(2,1,0,1,1,0, 0,0,1,0), M_ALL);
        run_ticks(2);
        expect_now("idle_t6", v(3,2,1,1,2,1, 0,0,1,0), M_ALL);

        // Hunger 14, FEED on the same cycle as a hunger age event
        do_reset();
        run_ticks(29);
        expect_now("pre_feed_t29", v(14,9,9,7,9,5, 0,0,1,0), M_ALL);
        wait_tick();
        do_action(ACT_FEED);
        expect_now("feed_with_age", v(11,10,10,7,10,6, 0,0,1,0), M_ALL);

        // Sleep drains energy, PLAY discarded, wakes after energy hits 0
        do_reset();
        run_ticks(9);
        expect_now("pre_sleep_t9", v(4,3,1,2,3,1, 0,0,1,0), M_ALL);
        do_action(ACT_SLEEP);
        expect_now("asleep", v(4,3,1,2,3,1, 1,0,1,0), M_ALL);
        run_ticks(1);
        expect_now("sleep_t10", v(5,3,1,2,2,2, 1,0,1,0), M_ALL);
        do_action(ACT_PLAY);
        expect_now("play_in_sleep", v(5,3,1,2,2,2, 1,0,1,0), M_ALL);
        run_ticks(1);
        expect_now("sleep_t11", v(5,3,1,2,1,2, 1,0,1,0), M_ALL);
        run_ticks(1);
        expect_now("sleep_t12", v(6,3,2,3,0,2, 1,0,1,0), M_ALL);
        step();
        expect_now("woke_up", v(6,3,2,3,0,2, 0,0,1,0), M_ALL);

        // Hygiene 12 forces health ageing; medicine clamps; saturation at 15
        do_reset();
        for (int k = 0; k < 6; k++) begin
            run_ticks(8);
            do_action(ACT_FEED);
        end
        expect_now("t48_saturated", v(0,15,8,12,15,9, 0,0,1,0), M_ALL);
        do_action(ACT_MEDICINE);
        expect_now("med_8_to_2", v(0,15,2,12,15,9, 0,0,1,0), M_ALL);
        run_ticks(1);
        expect_now("alert_t49", v(0,15,3,12,15,9, 0,0,1,0), M_ALL);
        run_ticks(1);
        expect_now("alert_t50", v(1,15,4,12,15,10, 0,0,1,0), M_ALL);
        do_action(ACT_MEDICINE);
        expect_now("med_clamp", v(1,15,0,12,15,10, 0,0,1,0), M_ALL);
        do_action(ACT_CLEAN);
        expect_now("clean", v(1,15,0,0,15,10, 0,0,1,0), M_ALL);
        run_ticks(1);
        expect_now("no_alert_t51", v(1,15,0,0,15,10, 0,0,1,0), M_ALL);
        do_action(ACT_PLAY);
        expect_now("play_energy_sat", v(1,11,0,0,15,10, 0,0,1,0), M_ALL);
        do_action(ACT_SOCIALIZE);
        expect_now("socialize", v(1,10,0,0,15,6, 0,0,1,0), M_ALL);

        // Death by hunger, frozen levels, actions refused, reset recovers
        do_reset();
        run_ticks(30);
        expect_now("hunger_15", v(15,10,10,7,10,6, 0,0,1,0), M_ALL);
        step();
        expect_now("dead", v(15,10,10,7,10,6, 0,1,0,0), M_ALL);
        run_ticks(20);
        expect_now("dead_frozen", v(15,10,10,7,10,6, 0,1,0,0), M_ALL);
        do_action(ACT_FEED);
        expect_now("dead_feed_ignored", v(15,10,10,7,10,6, 0,1,0,0), M_ALL);
        do_reset();

        // Reset mid-sleep, coincident with a tick and FEED
        run_ticks(9);
        do_action(ACT_SLEEP);
        expect_now("asleep_again", v(4,3,1,2,3,1, 1,0,1,0), M_ALL);
        wait_tick();
        reset = 1'b1;
        action_valid = 1'b1;
        action_code = ACT_FEED;
        step();
        reset = 1'b0;
        action_valid = 1'b0;
        expect_now("reset_mid_sleep", v(0,0,0,0,0,0, 0,0,1,0), M_ALL);
        for (int c = 1; c <= 4; c++) begin
            step();
            expect_now($sformatf("restart_tick%0d", c), v(0,0,0,0,0,0, 0,0,0,(c == 4) ? 1 : 0), M_TICK);
        end
        step();
        expect_now("after_restart_t1", v(0,0,0,0,0,0, 0,0,1,0), M_ALL);

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
